// File: rtl/regfile_write_port_if.sv
// Write-request handshake bundle between the write-back stage and the
// register-file write port. The master drives the request; the slave replies
// with in_ready.
interface regfile_write_port_if #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned AW    = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [AW-1:0]    in_addr;
    logic [WIDTH-1:0] in_data;

    modport master (
        output in_valid,
        output in_addr,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_addr,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/regfile_write_port.sv
// Register-file write port: buffers write requests in a small circular FIFO
// and drains one per cycle as a registered one-hot word enable plus data.
// Optional feature macro: WRFWD_EN compiles in the combinational forwarding
// lookup (youngest pending write to fwd_addr). Without it, fwd_hit and
// fwd_data are tied to zero and fwd_addr is ignored.
module regfile_write_port #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned NREG     = 32,
    parameter int unsigned ZERO_REG = 31
) (
    input  logic                      clk,
    input  logic                      reset_n,
    regfile_write_port_if.slave       req,
    input  logic                      wr_stall,
    output logic [NREG-1:0]           wr_en,
    output logic [WIDTH-1:0]          wr_data,
    input  logic [$clog2(NREG)-1:0]   fwd_addr,
    output logic                      fwd_hit,
    output logic [WIDTH-1:0]          fwd_data,
    output logic                      empty
);

    localparam int unsigned AW = $clog2(NREG);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [NREG-1:0]  wr_en_q, wr_en_d;
    logic [WIDTH-1:0] wr_data_q, wr_data_d;

    logic             push;
    logic             pop;
    entry_t           head_entry;

    // Ready depends on occupancy only; a same-cycle pop never frees a full buffer.
    assign req.in_ready = (count_q != CW'(DEPTH));
    assign push         = req.in_valid && req.in_ready;
    assign pop          = (count_q != '0) && !wr_stall;
    assign head_entry   = mem_q[head_q];

    // Next-state: pointer/count update and output-register load on pop.
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        wr_en_d   = '0;
        wr_data_d = wr_data_q;

        if (push) begin
            tail_d = tail_q + PW'(1);
        end

        if (pop) begin
            head_d    = head_q + PW'(1);
            wr_data_d = head_entry.data;
            if ((head_entry.addr != AW'(ZERO_REG)) && (32'(head_entry.addr) < NREG)) begin
                wr_en_d[head_entry.addr] = 1'b1;
            end
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state and output register, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            wr_en_q   <= '0;
            wr_data_q <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Buffer storage; contents are only meaningful between head and tail.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q].addr <= req.in_addr;
            mem_q[tail_q].data <= req.in_data;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_data = wr_data_q;
    assign empty   = (count_q == '0) && (wr_en_q == '0);

`ifdef WRFWD_EN
    // Forwarding lookup: output register first, then FIFO head to tail so the
    // youngest matching entry overrides older ones.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (fwd_addr != AW'(ZERO_REG)) begin
            if ((32'(fwd_addr) < NREG) && wr_en_q[fwd_addr]) begin
                fwd_hit  = 1'b1;
                fwd_data = wr_data_q;
            end
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if ((CW'(i) < count_q) && (mem_q[head_q + PW'(i)].addr == fwd_addr)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = mem_q[head_q + PW'(i)].data;
                end
            end
        end
    end
`else
    // Forwarding compiled out.
    logic unused_fwd_addr;
    assign unused_fwd_addr = ^fwd_addr;
    assign fwd_hit         = 1'b0;
    assign fwd_data        = '0;
`endif

endmodule

// File: tb/tb_regfile_write_port.sv
// Self-checking bench for regfile_write_port: directed vector table, hand
// sequences for multi-cycle corners, and random traffic against a queue model.
module tb_regfile_write_port;

    localparam int unsigned DEPTH    = 4;
    localparam int unsigned WIDTH    = 64;
    localparam int unsigned NREG     = 32;
    localparam int unsigned ZERO_REG = 31;
    localparam int unsigned AW       = 5;
    localparam int          NV       = 17;

`ifdef WRFWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
    } ent_t;

    typedef struct {
        logic             v;
        logic [AW-1:0]    a;
        logic [WIDTH-1:0] d;
        logic             st;
        logic [AW-1:0]    fa;
        logic             rdy;
        logic [NREG-1:0]  en;
        logic [WIDTH-1:0] wd;
        logic             emp;
        logic             hit;
    } vec_t;

    logic             clk;
    logic             reset_n;
    logic             wr_stall;
    logic [NREG-1:0]  wr_en;
    logic [WIDTH-1:0] wr_data;
    logic [AW-1:0]    fwd_addr;
    logic             fwd_hit;
    logic [WIDTH-1:0] fwd_data;
    logic             empty;

    regfile_write_port_if #(.WIDTH(WIDTH), .AW(AW)) req_if ();

    regfile_write_port #(
        .DEPTH(DEPTH), .WIDTH(WIDTH), .NREG(NREG), .ZERO_REG(ZERO_REG)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req(req_if.slave),
        .wr_stall(wr_stall),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .fwd_addr(fwd_addr),
        .fwd_hit(fwd_hit),
        .fwd_data(fwd_data),
        .empty(empty)
    );

    // Stimulus shadow copy and reference model state.
    logic             s_v;
    logic [AW-1:0]    s_a;
    logic [WIDTH-1:0] s_d;
    logic             s_st;
    logic [AW-1:0]    s_fa;
    ent_t             q[$];
    logic [NREG-1:0]  m_en;
    logic [WIDTH-1:0] m_wd;
    int unsigned      n_total = 0;
    int unsigned      n_pass  = 0;
    vec_t             tv [NV];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    function automatic vec_t mk(input logic v, input logic [AW-1:0] a, input logic [WIDTH-1:0] d,
                                input logic st, input logic [AW-1:0] fa, input logic rdy,
                                input logic [NREG-1:0] en, input logic [WIDTH-1:0] wd,
                                input logic emp, input logic hit);
        vec_t r;
        r.v = v; r.a = a; r.d = d; r.st = st; r.fa = fa;
        r.rdy = rdy; r.en = en; r.wd = wd; r.emp = emp; r.hit = hit;
        return r;
    endfunction

    // Compare every output against the queue model for the current cycle.
    task automatic model_check();
        logic             exp_hit;
        logic [WIDTH-1:0] exp_fd;
        exp_hit = 1'b0;
        exp_fd  = '0;
        if (FWD && (s_fa != AW'(ZERO_REG))) begin
            if (m_en[s_fa]) begin
                exp_hit = 1'b1;
                exp_fd  = m_wd;
            end
            foreach (q[i]) begin
                if (q[i].addr == s_fa) begin
                    exp_hit = 1'b1;
                    exp_fd  = q[i].data;
                end
            end
        end
        chk("model.in_ready", 64'(req_if.in_ready), 64'(q.size() != DEPTH));
        chk("model.wr_en",    64'(wr_en),           64'(m_en));
        chk("model.wr_data",  wr_data,              m_wd);
        chk("model.empty",    64'(empty),           64'((q.size() == 0) && (m_en == '0)));
        chk("model.fwd_hit",  64'(fwd_hit),         64'(exp_hit));
        chk("model.fwd_data", fwd_data,             exp_fd);
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] a, input logic [WIDTH-1:0] d,
                         input logic st, input logic [AW-1:0] fa);
        s_v = v; s_a = a; s_d = d; s_st = st; s_fa = fa;
        req_if.in_valid = v;
        req_if.in_addr  = a;
        req_if.in_data  = d;
        wr_stall        = st;
        fwd_addr        = fa;
        #1;
        model_check();
    endtask

    // Advance one clock and apply the spec rules to the model.
    task automatic tick();
        bit   do_pop;
        bit   do_push;
        ent_t h;
        ent_t e;
        do_pop  = (q.size() != 0) && !s_st;
        do_push = s_v && (q.size() != DEPTH);
        @(posedge clk);
        m_en = '0;
        if (do_pop) begin
            h    = q.pop_front();
            m_wd = h.data;
            if (h.addr != AW'(ZERO_REG)) m_en[h.addr] = 1'b1;
        end
        if (do_push) begin
            e.addr = s_a;
            e.data = s_d;
            q.push_back(e);
        end
        #1;
    endtask

    task automatic model_reset();
        q.delete();
        m_en = '0;
        m_wd = '0;
    endtask

    initial begin
        reset_n         = 1'b0;
        req_if.in_valid = 1'b0;
        req_if.in_addr  = '0;
        req_if.in_data  = '0;
        wr_stall        = 1'b0;
        fwd_addr        = '0;
        s_v = 1'b0; s_a = '0; s_d = '0; s_st = 1'b0; s_fa = '0;
        model_reset();

        // Single write, fill/backpressure, zero register.
        tv[0]  = mk(1, 5,  64'hDEAD_BEEF, 0, 5,  1, 32'h0,  64'h0,         1, 0);
        tv[1]  = mk(0, 0,  64'h0,         0, 5,  1, 32'h0,  64'h0,         0, 1);
        tv[2]  = mk(0, 0,  64'h0,         0, 5,  1, 32'h20, 64'hDEAD_BEEF, 0, 1);
        tv[3]  = mk(0, 0,  64'h0,         0, 5,  1, 32'h0,  64'hDEAD_BEEF, 1, 0);
        tv[4]  = mk(1, 1,  64'h111,       1, 0,  1, 32'h0,  64'hDEAD_BEEF, 1, 0);
        tv[5]  = mk(1, 2,  64'h222,       1, 0,  1, 32'h0,  64'hDEAD_BEEF, 0, 0);
        tv[6]  = mk(1, 3,  64'h333,       1, 0,  1, 32'h0,  64'hDEAD_BEEF, 0, 0);
        tv[7]  = mk(1, 4,  64'h444,       1, 4,  1, 32'h0,  64'hDEAD_BEEF, 0, 0);
        tv[8]  = mk(1, 5,  64'h555,       1, 4,  0, 32'h0,  64'hDEAD_BEEF, 0, 1);
        tv[9]  = mk(0, 0,  64'h0,         0, 0,  0, 32'h0,  64'hDEAD_BEEF, 0, 0);
        tv[10] = mk(0, 0,  64'h0,         0, 0,  1, 32'h2,  64'h111,       0, 0);
        tv[11] = mk(0, 0,  64'h0,         0, 0,  1, 32'h4,  64'h222,       0, 0);
        tv[12] = mk(0, 0,  64'h0,         0, 0,  1, 32'h8,  64'h333,       0, 0);
        tv[13] = mk(0, 0,  64'h0,         0, 0,  1, 32'h10, 64'h444,       0, 0);
        tv[14] = mk(1, 31, 64'h1234,      0, 31, 1, 32'h0,  64'h444,       1, 0);
        tv[15] = mk(0, 0,  64'h0,         0, 31, 1, 32'h0,  64'h444,       0, 0);
        tv[16] = mk(0, 0,  64'h0,         0, 31, 1, 32'h0,  64'h1234,      1, 0);

        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(tv[i].v, tv[i].a, tv[i].d, tv[i].st, tv[i].fa);
            chk($sformatf("vec%0d.in_ready", i), 64'(req_if.in_ready), 64'(tv[i].rdy));
            chk($sformatf("vec%0d.wr_en", i),    64'(wr_en),           64'(tv[i].en));
            chk($sformatf("vec%0d.wr_data", i),  wr_data,              tv[i].wd);
            chk($sformatf("vec%0d.empty", i),    64'(empty),           64'(tv[i].emp));
            chk($sformatf("vec%0d.fwd_hit", i),  64'(fwd_hit),         64'(tv[i].hit & FWD));
            tick();
        end

        // Forwarding: two writes to the same register, youngest wins.
        drive(1, 7, 64'hA, 1, 7); tick();
        drive(1, 7, 64'hB, 1, 7);
        chk("fwd.one_pending", fwd_data, FWD ? 64'hA : 64'h0);
        tick();
        drive(0, 0, 64'h0, 1, 7);
        chk("fwd.hit7",  64'(fwd_hit), 64'(FWD));
        chk("fwd.data7", fwd_data,     FWD ? 64'hB : 64'h0);
        drive(0, 0, 64'h0, 1, 8);
        chk("fwd.hit8",  64'(fwd_hit), 64'h0);
        tick();
        drive(0, 0, 64'h0, 0, 7); tick();
        drive(0, 0, 64'h0, 0, 7);
        chk("fwd.fifo_over_outreg", fwd_data, FWD ? 64'hB : 64'h0);
        tick();
        drive(0, 0, 64'h0, 0, 7);
        chk("fwd.outreg_hit", 64'(fwd_hit), 64'(FWD));
        tick();
        drive(0, 0, 64'h0, 0, 7);
        chk("fwd.drained", 64'(fwd_hit), 64'h0);
        tick();

        // Streaming with wrap-around and simultaneous push/pop.
        for (int j = 0; j < 12; j++) begin
            if (j < 10) drive(1, AW'(j), 64'(j) + 64'h100, 0, 0);
            else        drive(0, 0, 64'h0, 0, 0);
            chk($sformatf("stream%0d.in_ready", j), 64'(req_if.in_ready), 64'h1);
            if (j >= 2) chk($sformatf("stream%0d.wr_en", j), 64'(wr_en), 64'h1 << (j - 2));
            tick();
        end
        drive(0, 0, 64'h0, 0, 0);
        chk("stream.empty_after", 64'(empty), 64'h1);
        tick();

        // Mid-operation asynchronous reset with buffered writes.
        for (int j = 0; j < 3; j++) begin
            drive(1, AW'(j + 10), 64'hF00 + 64'(j), 1, 10);
            tick();
        end
        drive(0, 0, 64'h0, 1, 10);
        chk("rst.pre_not_empty", 64'(empty), 64'h0);
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("rst.wr_en",    64'(wr_en),           64'h0);
        chk("rst.in_ready", 64'(req_if.in_ready), 64'h1);
        chk("rst.empty",    64'(empty),           64'h1);
        chk("rst.fwd_hit",  64'(fwd_hit),         64'h0);
        chk("rst.fwd_data", fwd_data,             64'h0);
        chk("rst.wr_data",  wr_data,              64'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int j = 0; j < 6; j++) begin
            drive(0, 0, 64'h0, 0, 10);
            chk($sformatf("rst.post%0d.wr_en", j), 64'(wr_en), 64'h0);
            tick();
        end

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic [AW-1:0] ra;
            logic [AW-1:0] rf;
            ra = ($urandom_range(0, 9) == 0) ? AW'(ZERO_REG) : AW'($urandom_range(0, 7));
            rf = ($urandom_range(0, 9) == 0) ? AW'(ZERO_REG) : AW'($urandom_range(0, 8));
            drive($urandom_range(0, 99) < 60, ra, {$urandom, $urandom},
                  $urandom_range(0, 99) < 30, rf);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/regfile_write_port.md
# regfile_write_port

Write side of the register file: accepts write requests through a valid/ready handshake, buffers them in a small FIFO, and drains one per cycle as a registered one-hot word-enable plus data onto the register array. It is the write-decode counterpart of the mux-tree read path. It sits between the write-back stage and the 32×64 register array.

## Interface
- DEPTH, 4, write-buffer entries (power of two, ≥2)
- WIDTH, 64, data width
- NREG, 32, register count; address width is log2(NREG)
- ZERO_REG, 31, register index that is never written

- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  write request present
- in_ready  out  1  buffer can accept a request
- in_addr  in  5  destination register
- in_data  in  WIDTH  write data
- wr_stall  in  1  array busy, hold drain
- wr_en  out  NREG  one-hot word enable to the array, registered
- wr_data  out  WIDTH  data to the array, registered
- fwd_addr  in  5  lookup address from the read side
- fwd_hit  out  1  pending write to fwd_addr exists
- fwd_data  out  WIDTH  youngest pending data for fwd_addr
- empty  out  1  buffer empty and no write in flight

Clock and reset: one clock; reset is asynchronous and active-low.

## Operation
- Buffer: circular FIFO with head/tail pointers of log2(DEPTH) bits, plus a count of log2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- Push: occurs on a clock edge when in_valid && in_ready.
- in_ready = (count != DEPTH). It is not relaxed by a same-cycle pop, so a full buffer never accepts.
- Pop: occurs on a clock edge when count != 0 && !wr_stall.
  - The head entry loads the output register: wr_en = decode(addr), wr_data = data.
  - If the head addr == ZERO_REG, the entry is popped but wr_en loads all zeros. wr_data still loads.
- No pop (empty or stalled): wr_en loads all zeros and wr_data holds its value. wr_en is therefore high for exactly one cycle per write.
- Simultaneous push and pop: both take effect and count is unchanged. When count == 0, a pushed entry is not popped in the same cycle.
- wr_en is always one-hot or all zero. Two bits high at once is a design error.
- empty = (count == 0) && (wr_en == 0).
- Address decode: in_addr ≥ NREG cannot occur for NREG=32. For smaller NREG, out-of-range addresses decode to all zeros.
- Reset (asynchronous, mid-operation included) has the following effects:
  - Clears pointers, count, wr_en = 0, wr_data = 0.
  - Buffered writes are discarded.
  - Outputs: in_ready = 1, fwd_hit = 0, fwd_data = 0, empty = 1.

## Timing
- Latency: a request accepted at edge N into an empty, unstalled buffer drives wr_en during the cycle after edge N+1. The array captures it at edge N+2.
- Throughput: one write per cycle sustained with wr_stall low.
- wr_stall is sampled at the pop edge only. A write already in the output register is not held or repeated by wr_stall.
- in_ready is combinational from count only, with no path from in_valid.
- Forwarding lookup is combinational from fwd_addr and state:
  - Search order, youngest first: FIFO tail-1 down to head, then the output register.
  - An output-register match counts only while its wr_en bit is set.
  - fwd_addr == ZERO_REG always gives fwd_hit = 0 and fwd_data = 0.
  - A request being pushed in the same cycle is not visible to the lookup.

## Configuration
- WRFWD_EN defined: the forwarding lookup described above is compiled in.
- WRFWD_EN undefined: the comparator logic is removed, fwd_hit is tied to 0 and fwd_data to 0. fwd_addr is ignored. All other behaviour is identical.

## Test plan
- Reset then single write: push addr 5, data 0xDEAD_BEEF at edge 1. Required: wr_en = 0x0000_0020 and wr_data = 0xDEAD_BEEF for exactly the cycle after edge 2, then wr_en = 0 and empty = 1.
- Fill/backpressure: with wr_stall = 1, push addrs 1–4 and hold in_valid. Required: in_ready = 0 after the 4th push and the 5th request is not accepted. Then drop the stall. Required: wr_en is 0x2, 0x4, 0x8, 0x10 on consecutive cycles.
- Zero register: push addr 31, data 0x1234. Required: wr_en stays 0, the entry drains (empty = 1 two cycles later), and fwd_hit = 0 for fwd_addr = 31 throughout.
- Forwarding (WRFWD_EN): stall, push (7, 0xA) then (7, 0xB). Required: with fwd_addr = 7, fwd_hit = 1 and fwd_data = 0xB. With fwd_addr = 8, fwd_hit = 0.
- Wrap-around plus simultaneous push/pop: stream 10 writes with in_valid held high and no stall, addrs 0–9. Required: wr_en follows 1<<k in order with no gaps after the first, and count never exceeds 1.
- Mid-operation reset: buffer 3 entries under stall, then assert reset_n = 0 asynchronously. Required: wr_en = 0, in_ready = 1, and empty = 1 immediately. After release, no stale write ever appears.
